// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: pipeline controller FSM state encoding.
package cpu_types_pkg;

    // Pipeline controller states; 3-bit encoding is exported on the state port.
    typedef enum logic [2:0] {
        PC_RUN   = 3'd0,
        PC_DWAIT = 3'd1,
        PC_FLUSH = 3'd2,
        PC_HALT  = 3'd3
    } pctrl_state_t;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stage enables/flushes for a 5-stage pipeline, handling
// memory waits, redirects, load-use hazards, fetch stalls and halt.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_wsel,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        redirect,
    input  logic        mem_halt,
    output logic        pc_en,
    output logic        en_ifid,
    output logic        en_idex,
    output logic        en_exmem,
    output logic        en_memwb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        iREN,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] stall_cnt
);

    pctrl_state_t r_state;
    pctrl_state_t w_next;
    logic [15:0]  r_stall_cnt;
    logic         w_mem_req;
    logic         w_ldhaz;

    // Hazard and memory-request detection.
    always_comb begin
        w_mem_req = mem_dREN | mem_dWEN;
        w_ldhaz   = ex_dREN && (ex_wsel != 5'd0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    end

    // Zero-latency enable/flush decode and next-state selection.
    always_comb begin
        w_next      = r_state;
        pc_en       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exmem    = 1'b0;
        en_memwb    = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        case (r_state)
            PC_RUN: begin
                if (mem_halt) begin
                    // Drain the halt into WB while freezing fetch.
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
                    w_next = PC_HALT;
                end else if (w_mem_req && !dhit) begin
                    w_next = PC_DWAIT;
                end else if (redirect) begin
                    // Redirect wins over ldhaz: the flush removes the dependent op.
                    pc_en = 1'b1;
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
                    {flush_ifid, flush_idex, flush_exmem}  = 3'b111;
                    w_next = ihit ? PC_RUN : PC_FLUSH;
                end else if (w_ldhaz) begin
                    en_idex    = 1'b1;
                    en_exmem   = 1'b1;
                    en_memwb   = 1'b1;
                    flush_idex = 1'b1;
                end else if (!ihit) begin
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
                    flush_ifid = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
                end
            end
            PC_DWAIT: begin
                if (dhit) begin
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
                    // Without a fetch result the IF/ID slot must still be bubbled.
                    pc_en      = ihit;
                    flush_ifid = !ihit;
                    w_next     = PC_RUN;
                end
            end
            PC_FLUSH: begin
                // The in-flight fetch is from the old path; drop it even on ihit.
                {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
                flush_ifid = 1'b1;
                if (ihit) begin
                    w_next = PC_RUN;
                end
            end
            PC_HALT: begin
                w_next = PC_HALT;
            end
            default: begin
                w_next = PC_RUN;
            end
        endcase
    end

    // Status outputs derived from the registered state.
    always_comb begin
        iREN      = (r_state != PC_HALT);
        halted    = (r_state == PC_HALT);
        state     = r_state;
        stall_cnt = r_stall_cnt;
    end

    // State register.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state <= PC_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Saturating count of cycles where the PC is held outside HALT.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_state != PC_HALT) &&
                     (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, redirect, mem_halt;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb;
    logic        flush_ifid, flush_idex, flush_exmem, iREN, halted;
    logic [2:0]  state;
    logic [15:0] stall_cnt;
    logic [9:0]  outs;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // {pc_en, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex, fl_exmem, iREN, halted}
    localparam logic [9:0] P_NORM   = 10'b1111100010;
    localparam logic [9:0] P_LDH    = 10'b0011101010;
    localparam logic [9:0] P_REDIR  = 10'b1111111110;
    localparam logic [9:0] P_MWAIT  = 10'b0000000010;
    localparam logic [9:0] P_FETCH  = 10'b0111110010;
    localparam logic [9:0] P_HALTGO = 10'b0111100010;
    localparam logic [9:0] P_HALTED = 10'b0000000001;

    localparam logic [2:0] S_RUN = 3'd0, S_DWAIT = 3'd1, S_FLUSH = 3'd2, S_HALT = 3'd3;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
        .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .redirect(redirect), .mem_halt(mem_halt),
        .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex),
        .en_exmem(en_exmem), .en_memwb(en_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .iREN(iREN), .halted(halted), .state(state), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    assign outs = {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
                   flush_ifid, flush_idex, flush_exmem, iREN, halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_dREN = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        redirect = 1'b0; mem_halt = 1'b0;
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b1;
        idle();
        #1;
        check("rst_state", 32'(state), 32'(S_RUN));
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge CLK);
        nRST = 1'b0;
        tick();
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        do_reset();

        // Normal flow and load-use hazards
        #1; check("norm_outs", 32'(outs), 32'(P_NORM));
        check("norm_state", 32'(state), 32'(S_RUN));
        tick();
        ex_dREN = 1'b1; ex_wsel = 5'd2; id_rs = 5'd2; id_rt = 5'd5;
        #1; check("ldh_rs_outs", 32'(outs), 32'(P_LDH));
        tick();
        ex_dREN = 1'b0;
        #1; check("ldh_after_outs", 32'(outs), 32'(P_NORM));
        check("ldh_cnt", 32'(stall_cnt), 32'd1);
        tick();
        ex_dREN = 1'b1; ex_wsel = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        #1; check("ldh_rt_outs", 32'(outs), 32'(P_LDH));
        tick();
        ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1; check("ldh_r0_outs", 32'(outs), 32'(P_NORM));
        tick();
        ex_dREN = 1'b0; ex_wsel = 5'd4; id_rs = 5'd4;
        #1; check("no_load_outs", 32'(outs), 32'(P_NORM));
        tick();
        ex_dREN = 1'b1; redirect = 1'b1;
        #1; check("redir_ldh_outs", 32'(outs), 32'(P_REDIR));
        tick();
        idle();
        #1; check("redir_ihit_state", 32'(state), 32'(S_RUN));
        check("cnt_2", 32'(stall_cnt), 32'd2);

        // Data-memory wait (priority over redirect)
        mem_dREN = 1'b1; redirect = 1'b1;
        #1; check("dmiss_outs", 32'(outs), 32'(P_MWAIT));
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1; check("dwait_state", 32'(state), 32'(S_DWAIT));
            check("dwait_outs", 32'(outs), 32'(P_MWAIT));
            tick();
        end
        dhit = 1'b1;
        #1; check("dhit_state", 32'(state), 32'(S_DWAIT));
        check("dhit_outs", 32'(outs), 32'(P_NORM));
        tick();
        mem_dREN = 1'b0; mem_dWEN = 1'b1;
        #1; check("dwait_exit_state", 32'(state), 32'(S_RUN));
        check("dwait_cnt", 32'(stall_cnt), 32'd5);
        check("store_hit_outs", 32'(outs), 32'(P_NORM));
        tick();
        idle();

        // Redirect with fetch outstanding
        redirect = 1'b1; ihit = 1'b0;
        #1; check("redir_miss_outs", 32'(outs), 32'(P_REDIR));
        tick();
        redirect = 1'b0;
        #1; check("flush_state", 32'(state), 32'(S_FLUSH));
        check("flush_outs", 32'(outs), 32'(P_FETCH));
        tick();
        ihit = 1'b1;
        #1; check("flush_ihit_outs", 32'(outs), 32'(P_FETCH));
        tick();
        #1; check("flush_exit_state", 32'(state), 32'(S_RUN));
        check("flush_cnt", 32'(stall_cnt), 32'd7);
        ihit = 1'b0;
        #1; check("imiss_outs", 32'(outs), 32'(P_FETCH));
        tick();
        ihit = 1'b1;
        #1; check("imiss_state", 32'(state), 32'(S_RUN));
        check("imiss_cnt", 32'(stall_cnt), 32'd8);

        // Reset in the middle of a DWAIT
        mem_dREN = 1'b1;
        tick();
        #1; check("pre_rst_state", 32'(state), 32'(S_DWAIT));
        #1; nRST = 1'b1;
        #1; check("mid_rst_state", 32'(state), 32'(S_RUN));
        check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        idle();
        @(negedge CLK);
        nRST = 1'b0;
        tick();
        #1; check("post_rst_outs", 32'(outs), 32'(P_NORM));
        tick();
        #1; check("post_rst_state", 32'(state), 32'(S_RUN));

        // Halt is sticky regardless of inputs
        mem_halt = 1'b1;
        #1; check("halt_go_outs", 32'(outs), 32'(P_HALTGO));
        tick();
        for (int i = 0; i < 10; i++) begin
            {ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, redirect, mem_halt} = 7'($urandom);
            ex_wsel = 5'($urandom); id_rs = ex_wsel; id_rt = 5'($urandom);
            #1; check("halt_outs", 32'(outs), 32'(P_HALTED));
            check("halt_state", 32'(state), 32'(S_HALT));
            check("halt_cnt", 32'(stall_cnt), 32'd1);
            tick();
        end
        do_reset();

        // Stall counter saturation
        ihit = 1'b0;
        repeat (65534) tick();
        #1; check("cnt_fffe", 32'(stall_cnt), 32'h0000FFFE);
        repeat (70000 - 65534) tick();
        #1; check("cnt_sat", 32'(stall_cnt), 32'h0000FFFF);
        check("sat_state", 32'(state), 32'(S_RUN));
        tick();
        #1; check("cnt_sat_hold", 32'(stall_cnt), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, rising edge; nRST  in  1  reset, asynchronous, active-high (asserted when 1).
REQ-002 SHALL have inputs: ihit 1 imem fetch done; dhit 1 dmem access done; mem_dREN 1 and mem_dWEN 1 for the load/store in MEM; ex_dREN 1 for the load in EX; ex_wsel 5 EX destination; id_rs 5 and id_rt 5 ID sources; redirect 1 branch taken or j/jal/jr resolved in MEM; mem_halt 1 halt in MEM.
REQ-003 SHALL have outputs: pc_en 1; en_ifid, en_idex, en_exmem, en_memwb 1 each, stage load enables; flush_ifid, flush_idex, flush_exmem 1 each, stage zeroing; iREN 1; halted 1; state 3, current FSM state; stall_cnt 16, saturating stall-cycle count.

Function
REQ-004 SHALL implement FSM states RUN, DWAIT, FLUSH, HALT with a registered state.
REQ-005 SHALL compute all enables and flushes combinationally from state and inputs, with zero latency.
REQ-006 SHALL define mem_req = mem_dREN | mem_dWEN and ldhaz = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt).
REQ-007 SHALL, in RUN, apply priority mem_halt > (mem_req & !dhit) > redirect > ldhaz > !ihit > normal.
REQ-008 SHALL, in RUN with mem_halt, drive all en_* to 1 and pc_en to 0 so the halt reaches WB, and move to HALT.
REQ-009 SHALL, in RUN with mem_req & !dhit, drive all en_*, pc_en and flushes to 0 and move to DWAIT.
REQ-010 SHALL, in DWAIT, hold all en_*/pc_en at 0 until dhit; in the dhit cycle it drives all en_* and pc_en to 1 (with ihit=1) and returns to RUN.
REQ-011 SHALL, on redirect in RUN, drive pc_en=1, all en_*=1 and flush_ifid, flush_idex, flush_exmem=1; next state RUN if ihit=1, else FLUSH.
REQ-012 SHALL, in FLUSH, hold pc_en=0 and flush_ifid=1 with downstream en_*=1 until ihit, discarding the stale fetch; on ihit it returns to RUN.
REQ-013 SHALL, on ldhaz in RUN, drive pc_en=0, en_ifid=0, flush_idex=1 and en_exmem=en_memwb=1 for exactly one bubble.
REQ-014 SHALL, on !ihit in RUN with no higher event, drive pc_en=0, flush_ifid=1 and downstream en_*=1.
REQ-015 SHALL, in HALT, drive all en_*, pc_en and iREN to 0 and halted to 1; HALT is sticky until reset.
REQ-016 SHALL drive iREN=1 in every state except HALT.
REQ-017 SHALL increment stall_cnt by 1 per cycle with pc_en=0 outside HALT, saturating at 0xFFFF.
REQ-018 SHALL treat simultaneous redirect and ldhaz as redirect only, because the flush removes the hazard.

Reset
REQ-019 SHALL, while nRST=1, asynchronously force state=RUN, stall_cnt=0 and halted=0.
REQ-020 SHALL abandon any DWAIT/FLUSH/HALT on reset mid-operation, with no pending event retained.

Structure
REQ-021 SHALL declare the FSM state enum (3-bit) in cpu_types_pkg as pctrl_state_t.
REQ-022 SHALL use a single module without sub-modules; the hazard compare is inline combinational logic.

Verification
REQ-023 SHALL cover this case: lw $2 in EX with id_rs=2 -> one cycle of pc_en=0, en_ifid=0, flush_idex=1, then normal flow.
REQ-024 SHALL cover this case: mem_dREN=1 with dhit low for 3 cycles -> state DWAIT for 3 cycles, all en_*=0, stall_cnt=+3 (pc_en=0 each cycle), RUN after dhit.
REQ-025 SHALL cover this case: redirect=1 with ihit=0 -> three flushes that cycle, FLUSH until ihit, then RUN.
REQ-026 SHALL cover this case: mem_halt=1 -> en_memwb=1 that cycle, then halted=1, iREN=0, held for 10 cycles regardless of inputs.
REQ-027 SHALL cover this case: nRST asserted mid-DWAIT -> immediate state RUN, stall_cnt=0, halted=0.
REQ-028 SHALL cover this case: stall_cnt preset near 0xFFFF by 70000 forced ihit=0 cycles -> holds at 0xFFFF.
